param_delay_box: RTL and testbench

Parametrised delay/recirculation line that carries WIDTH-bit data words with a valid flag through DEPTH register stages. Parameters of integer, sized-integer and string type select its width, depth, reset value and operating mode, including deliberate truncation of an oversized sized parameter. It sits in the round-trip parameter-type suite as the sequential successor to the single-wire parameter box. It must survive read/write round-trips with all parameter and localparam values intact.

---
 rtl/param_box_pkg.sv | 12 +
 rtl/param_box_stage.sv | 25 ++
 rtl/param_delay_box.sv | 86 ++++++++
 tb/tb_param_delay_box.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/param_box_pkg.sv
// Shared constants and helpers for the parameter-type box family.
package param_box_pkg;

  localparam string MODE_DELAY          = "DELAY";
  localparam string MODE_ROTATE         = "ROTATE";
  localparam int    RESET_VALUE_DEFAULT = 65535;

  function automatic bit mode_is_legal(input string mode);
    return (mode == MODE_DELAY) || (mode == MODE_ROTATE);
  endfunction

endpackage

// File: rtl/param_box_stage.sv
// One delay-line stage: a data word plus its valid flag, advancing only when enabled.
module param_box_stage #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= RESET_WORD;
    end else if (en) begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/param_delay_box.sv
// Parametrised delay / recirculation line of DEPTH stages carrying WIDTH-bit words
// with valid flags, plus a running count of occupied stages.
module param_delay_box
  import param_box_pkg::*;
#(
  parameter int         WIDTH       = 8,
  parameter int         DEPTH       = 4,
  parameter logic [7:0] RESET_VALUE = 8'(RESET_VALUE_DEFAULT),
  parameter string      MODE        = "DELAY",
  localparam int        CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] fill_count
);

  localparam logic [7:0]       LOCAL_OVERSIZE = 8'(70123);
  localparam logic [WIDTH-1:0] RESET_WORD     = WIDTH'(RESET_VALUE);
  localparam bit               IS_ROTATE      = (MODE == MODE_ROTATE);

  if (!mode_is_legal(MODE)) begin : g_bad_mode
    $error("param_delay_box: MODE must be DELAY or ROTATE, got %s", MODE);
  end
  if (WIDTH < 1 || DEPTH < 1) begin : g_bad_size
    $error("param_delay_box: WIDTH and DEPTH must be at least 1");
  end
  // The oversized constant feeds no logic; this only pins its truncated value.
  if (LOCAL_OVERSIZE != 8'hEB) begin : g_bad_oversize
    $error("param_delay_box: LOCAL_OVERSIZE truncation changed");
  end

  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic             stage_valid [DEPTH];
  logic             recirc;
  logic             head_valid;
  logic [WIDTH-1:0] head_data;

  // In ROTATE an idle input feeds the output stage back into stage 0.
  assign recirc     = IS_ROTATE && !in_valid;
  assign head_valid = recirc ? out_valid : in_valid;
  assign head_data  = recirc ? out_data  : in_data;

  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             d_valid;
    logic [WIDTH-1:0] d_data;

    if (i == 0) begin : g_head
      assign d_valid = head_valid;
      assign d_data  = head_data;
    end else begin : g_tail
      assign d_valid = stage_valid[i-1];
      assign d_data  = stage_data[i-1];
    end

    param_box_stage #(
      .WIDTH      (WIDTH),
      .RESET_WORD (RESET_WORD)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .d_valid (d_valid),
      .d_data  (d_data),
      .q_valid (stage_valid[i]),
      .q_data  (stage_data[i])
    );
  end

  // Recirculation preserves the set of valid flags, so the count only moves otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count <= '0;
    end else if (en && !recirc) begin
      fill_count <= fill_count + CNT_W'(in_valid) - CNT_W'(out_valid);
    end
  end

endmodule

// File: tb/tb_param_delay_box.sv
// Directed bench for param_delay_box: default DELAY line, a ROTATE line and a
// 12-bit single-stage ROTATE line with a truncated reset value.
module tb_param_delay_box;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;

  logic        d_valid, r_valid, w_valid;
  logic [7:0]  d_data, r_data;
  logic [11:0] w_data;
  logic [2:0]  d_fill, r_fill;
  logic [0:0]  w_fill;

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  param_delay_box u_delay (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data[7:0]),
    .out_valid(d_valid), .out_data(d_data), .fill_count(d_fill)
  );

  param_delay_box #(.MODE("ROTATE")) u_rot (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data[7:0]),
    .out_valid(r_valid), .out_data(r_data), .fill_count(r_fill)
  );

  param_delay_box #(.WIDTH(12), .DEPTH(1), .RESET_VALUE(8'(300)), .MODE("ROTATE")) u_wide (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .out_valid(w_valid), .out_data(w_data), .fill_count(w_fill)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; in_valid = 1'b0; in_data = '0;
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1; in_valid = 1'b1; in_data = 12'h5A5;
    rst_n = 1'b0;
    #12;
    vec_count++; if (d_data !== 8'hFF) begin miss_count++; $display("[TB] FAIL reset_d_data got %h expected ff", d_data); end
    vec_count++; if (d_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_d_valid got %b expected 0", d_valid); end
    vec_count++; if (d_fill !== 3'd0) begin miss_count++; $display("[TB] FAIL reset_d_fill got %0d expected 0", d_fill); end
    vec_count++; if (r_data !== 8'hFF) begin miss_count++; $display("[TB] FAIL reset_r_data got %h expected ff", r_data); end
    vec_count++; if (w_data !== 12'h02C) begin miss_count++; $display("[TB] FAIL reset_w_data got %h expected 02c", w_data); end
    vec_count++; if (w_fill !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_w_fill got %0d expected 0", w_fill); end
    do_reset();
  endtask

  task automatic test_delay();
    int din[7]   = '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66, 'h77};
    int vin[7]   = '{1, 1, 1, 1, 1, 0, 0};
    int e_fill[7] = '{1, 2, 3, 4, 4, 3, 2};
    int e_val[7]  = '{0, 0, 0, 1, 1, 1, 1};
    int e_dat[7]  = '{'hFF, 'hFF, 'hFF, 'h11, 'h22, 'h33, 'h44};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = vin[i][0];
      in_data  = 12'(din[i]);
      tick();
      vec_count++; if (d_fill !== 3'(e_fill[i])) begin miss_count++; $display("[TB] FAIL delay_fill[%0d] got %0d expected %0d", i, d_fill, e_fill[i]); end
      vec_count++; if (d_valid !== e_val[i][0]) begin miss_count++; $display("[TB] FAIL delay_valid[%0d] got %b expected %0d", i, d_valid, e_val[i]); end
      vec_count++; if (d_data !== 8'(e_dat[i])) begin miss_count++; $display("[TB] FAIL delay_data[%0d] got %h expected %h", i, d_data, e_dat[i]); end
    end
  endtask

  task automatic test_stall();
    int e_en[7]   = '{1, 0, 0, 1, 1, 1, 1};
    int din[7]    = '{'h11, 'hEE, 'hEE, 'h22, 'h33, 'h44, 'h55};
    int e_fill[7] = '{1, 1, 1, 2, 3, 4, 4};
    int e_val[7]  = '{0, 0, 0, 0, 0, 1, 1};
    int e_dat[7]  = '{'hFF, 'hFF, 'hFF, 'hFF, 'hFF, 'h11, 'h22};
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en      = e_en[i][0];
      in_data = 12'(din[i]);
      tick();
      vec_count++; if (d_fill !== 3'(e_fill[i])) begin miss_count++; $display("[TB] FAIL stall_fill[%0d] got %0d expected %0d", i, d_fill, e_fill[i]); end
      vec_count++; if (d_valid !== e_val[i][0]) begin miss_count++; $display("[TB] FAIL stall_valid[%0d] got %b expected %0d", i, d_valid, e_val[i]); end
      vec_count++; if (d_data !== 8'(e_dat[i])) begin miss_count++; $display("[TB] FAIL stall_data[%0d] got %h expected %h", i, d_data, e_dat[i]); end
    end
  endtask

  task automatic test_rotate();
    int e_dat[8] = '{'hA1, 'hA2, 'hA3, 'hA0, 'hA1, 'hA2, 'hA3, 'hA0};
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 12'('hA0 + i);
      tick();
      vec_count++; if (r_fill !== 3'(i + 1)) begin miss_count++; $display("[TB] FAIL rot_load_fill[%0d] got %0d expected %0d", i, r_fill, i + 1); end
    end
    vec_count++; if (r_data !== 8'hA0) begin miss_count++; $display("[TB] FAIL rot_load_data got %h expected a0", r_data); end
    in_valid = 1'b0; in_data = 12'h05C;
    for (int i = 0; i < 8; i++) begin
      tick();
      vec_count++; if (r_data !== 8'(e_dat[i])) begin miss_count++; $display("[TB] FAIL rot_data[%0d] got %h expected %h", i, r_data, e_dat[i]); end
      vec_count++; if (r_fill !== 3'd4 || r_valid !== 1'b1) begin miss_count++; $display("[TB] FAIL rot_fill[%0d] got %0d/%b expected 4/1", i, r_fill, r_valid); end
    end
  endtask

  task automatic test_depth1();
    int vin[6]  = '{1, 0, 0, 0, 1, 1};
    int enb[6]  = '{1, 1, 1, 1, 1, 0};
    int din[6]  = '{'hABC, 'h123, 'h456, 'h789, 'h5A5, 'h777};
    int e_dat[6] = '{'hABC, 'hABC, 'hABC, 'hABC, 'h5A5, 'h5A5};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      en       = enb[i][0];
      in_valid = vin[i][0];
      in_data  = 12'(din[i]);
      tick();
      vec_count++; if (w_data !== 12'(e_dat[i])) begin miss_count++; $display("[TB] FAIL d1_data[%0d] got %h expected %h", i, w_data, e_dat[i]); end
      vec_count++; if (w_fill !== 1'b1 || w_valid !== 1'b1) begin miss_count++; $display("[TB] FAIL d1_fill[%0d] got %0d/%b expected 1/1", i, w_fill, w_valid); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 12'('h31 + i);
      tick();
    end
    vec_count++; if (d_fill !== 3'd3) begin miss_count++; $display("[TB] FAIL async_pre_fill got %0d expected 3", d_fill); end
    vec_count++; if (w_data !== 12'h033) begin miss_count++; $display("[TB] FAIL async_pre_w_data got %h expected 033", w_data); end
    #2;
    rst_n = 1'b0;
    #1;
    vec_count++; if (d_fill !== 3'd0) begin miss_count++; $display("[TB] FAIL async_d_fill got %0d expected 0", d_fill); end
    vec_count++; if (r_fill !== 3'd0) begin miss_count++; $display("[TB] FAIL async_r_fill got %0d expected 0", r_fill); end
    vec_count++; if (w_data !== 12'h02C) begin miss_count++; $display("[TB] FAIL async_w_data got %h expected 02c", w_data); end
    vec_count++; if (w_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL async_w_valid got %b expected 0", w_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_delay();
    test_stall();
    test_rotate();
    test_depth1();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
